// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock, valid/ready on both sides.
// Optional accumulate: define SEQ_MULT_ACC_EN to add a captured 2*WIDTH-bit addend to the product.
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     x,
    input  logic                 is_signed,
    input  logic [2*WIDTH-1:0]   acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     a_q;
    logic [WIDTH+1:0]   hi_q;
    logic [WIDTH:0]     lo_q;
    logic               prev_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [2*WIDTH-1:0] p_q;

    logic               accept_d;
    logic [WIDTH:0]     a_ext_d;
    logic [WIDTH:0]     x_ext_d;
    logic [WIDTH+1:0]   sum_d;
    logic [WIDTH+1:0]   hi_d;
    logic [WIDTH:0]     lo_d;
    logic [2*WIDTH-1:0] p_d;

    assign accept_d = in_valid && in_ready_q;
    assign a_ext_d  = is_signed ? {a[WIDTH-1], a} : {1'b0, a};
    assign x_ext_d  = is_signed ? {x[WIDTH-1], x} : {1'b0, x};

    // hi carries one guard bit above the extended operand so add/subtract never overflows
    always_comb begin
        sum_d = hi_q;
        case ({lo_q[0], prev_q})
            2'b01:   sum_d = hi_q + {a_q[WIDTH], a_q};
            2'b10:   sum_d = hi_q - {a_q[WIDTH], a_q};
            default: sum_d = hi_q;
        endcase
        hi_d = {sum_d[WIDTH+1], sum_d[WIDTH+1:1]};
        lo_d = {sum_d[0], lo_q[WIDTH:1]};
    end

`ifdef SEQ_MULT_ACC_EN
    logic [2*WIDTH-1:0] acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept_d) begin
            acc_q <= acc;
        end
    end

    assign p_d = {hi_q[WIDTH-2:0], lo_q} + acc_q;
`else
    logic unused_acc;
    assign unused_acc = ^acc;
    assign p_d        = {hi_q[WIDTH-2:0], lo_q};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            prev_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            p_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        state_q    <= BUSY;
                        cnt_q      <= '0;
                        a_q        <= a_ext_d;
                        hi_q       <= '0;
                        lo_q       <= x_ext_d;
                        prev_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    // the cycle after the last step only publishes the result
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        p_q         <= p_d;
                    end else begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        prev_q <= lo_q[0];
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign P         = p_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier (WIDTH=32): directed corners plus a random stream
// checked every cycle against a plain-arithmetic model.
module tb_seq_booth_multiplier;
    localparam int WIDTH = 32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] x;
    logic        is_signed;
    logic [63:0] acc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] P;

    int tests;
    int fails;
    int cyc;
    int accept_edge;
    int pushed;
    int popped;
    bit inflight;
    logic [63:0] last_p;
    logic [63:0] exp_q[$];

    seq_booth_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .x         (x),
        .is_signed (is_signed),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mul_model(input logic [31:0] ma, input logic [31:0] mx,
                                              input logic ms);
        logic [63:0] ea;
        logic [63:0] ex;
        ea = ms ? {{32{ma[31]}}, ma} : {32'h0, ma};
        ex = ms ? {{32{mx[31]}}, mx} : {32'h0, mx};
        return ea * ex;
    endfunction

    // Per-cycle reference: one operation in flight, fixed latency, result held until taken.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            exp_q.delete();
            inflight = 1'b0;
            last_p   = '0;
        end else begin
            check("in_ready", in_ready, !inflight);
            check("out_valid", out_valid, inflight && (cyc >= accept_edge + WIDTH + 2));
            if (out_valid && exp_q.size() > 0)
                check("P_model", P, exp_q[0]);
            else if (!out_valid)
                check("P_hold", P, last_p);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                last_p   = exp_q.pop_front();
                inflight = 1'b0;
                popped++;
            end
            if (in_valid && in_ready) begin
                e = mul_model(a, x, is_signed);
`ifdef SEQ_MULT_ACC_EN
                e = e + acc;
`endif
                exp_q.push_back(e);
                inflight    = 1'b1;
                accept_edge = cyc + 1;
                pushed++;
            end
        end
    end

    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        check({nm, "_accept"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [31:0] aa, input logic [31:0] xx,
                          input logic s, input logic [63:0] ac, input logic [63:0] exp,
                          input int stall);
        int lat;
        @(posedge clk);
        #1;
        a = aa; x = xx; is_signed = s; acc = ac;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        wait_accept(nm);
        a = $urandom; x = $urandom; is_signed = ~s; acc = {$urandom, $urandom};
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
        check({nm, "_latency"}, 64'(lat), 64'(WIDTH + 2));
        check({nm, "_P"}, P, exp);
        if (stall != 0) begin
            repeat (20) begin
                @(negedge clk);
                check({nm, "_stall_P"}, P, exp);
                check({nm, "_stall_in_ready"}, in_ready, 1'b0);
                check({nm, "_stall_out_valid"}, out_valid, 1'b1);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check({nm, "_drop"}, out_valid, 1'b0);
        check({nm, "_keep_P"}, P, exp);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'h0000_0000;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int push0;
        int pop0;
        bit stream_done;
        tests = 0; fails = 0; cyc = 0; pushed = 0; popped = 0;
        inflight = 1'b0; last_p = '0; accept_edge = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; x = '0; is_signed = 1'b0; acc = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_P", P, 64'h0);
        rst = 1'b0;

`ifndef SEQ_MULT_ACC_EN
        run_op("s_m1_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, '0, 64'h0000_0000_0000_0001, 0);
        run_op("s_m10_5",   32'hFFFF_FFF6, 32'h0000_0005, 1'b1, '0, 64'hFFFF_FFFF_FFFF_FFCE, 0);
        run_op("s_max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, '0, 64'h3FFF_FFFF_0000_0001, 0);
        run_op("s_min_m1",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, '0, 64'h0000_0000_8000_0000, 0);
        run_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, '0, 64'h4000_0000_0000_0000, 0);
        run_op("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '0, 64'hFFFF_FFFE_0000_0001, 0);
        run_op("u_max_2",   32'h7FFF_FFFF, 32'h0000_0002, 1'b0, '0, 64'h0000_0000_FFFF_FFFE, 0);
        run_op("lat_stall", 32'd543,       32'd9889,      1'b0, '0, 64'd5369727,             1);
`else
        run_op("acc_3_4",   32'd3,         32'd4,         1'b1, 64'd100, 64'd112, 0);
        run_op("acc_m1_1",  32'hFFFF_FFFF, 32'd1,         1'b1, 64'd0,   64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("acc_wrap",  32'd1,         32'd1,         1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        run_op("acc_stall", 32'd543,       32'd9889,      1'b0, 64'd0,   64'd5369727, 1);
`endif

        // abort mid-operation: nothing may come out afterwards
        @(posedge clk);
        #1;
        a = 32'd7; x = 32'd9; is_signed = 1'b0; acc = '0; in_valid = 1'b1;
        wait_accept("rst_op");
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_P", P, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("rst_no_result", 64'(n), 64'd0);

        push0 = pushed;
        pop0  = popped;
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk);
                    #1;
                    a = pick(); x = pick(); is_signed = 1'($urandom_range(0, 1));
                    acc = {$urandom, $urandom};
                    in_valid = 1'b1;
                    wait_accept("stream");
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while ((popped - pop0) != (pushed - push0) && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("stream_accepted", 64'(pushed - push0), 64'd200);
        check("stream_drained", 64'(popped - pop0), 64'(pushed - push0));
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
